// File: rtl/if_id_pkg.sv
// Shared types and default widths for the IF/ID elastic pipeline register.
// The state encoding mirrors {skid_valid, main_valid}, so HALF and FULL read directly off the valid bits.
package if_id_pkg;

  localparam int DEF_INST_SIZE = 32;
  localparam int DEF_PC_SIZE   = 32;
  localparam int DEF_CNT_SIZE  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } state_e;

endpackage

// File: rtl/if_id_entry.sv
// One buffer slot: valid bit plus {pc, instruction}, with load enable and valid-clear.
// Clear wins over load and leaves the data untouched; data is don't-care while the slot is invalid.
module if_id_entry
  import if_id_pkg::*;
#(
  parameter int PC_SIZE   = DEF_PC_SIZE,
  parameter int INST_SIZE = DEF_INST_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clr,
  input  logic [PC_SIZE-1:0]   d_pc,
  input  logic [INST_SIZE-1:0] d_instruction,
  output logic                 valid,
  output logic [PC_SIZE-1:0]   pc,
  output logic [INST_SIZE-1:0] instruction
);

  logic                 valid_q, valid_d;
  logic [PC_SIZE-1:0]   pc_q, pc_d;
  logic [INST_SIZE-1:0] instruction_q, instruction_d;

  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d       = 1'b1;
      pc_d          = d_pc;
      instruction_d = d_instruction;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      instruction_q <= '0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
    end
  end

  assign valid       = valid_q;
  assign pc          = pc_q;
  assign instruction = instruction_q;

endmodule

// File: rtl/if_id_buffer.sv
// Elastic IF/ID register: 2-entry skid buffer between fetch and decode with flush and a
// saturating flush-event counter. in_ready comes straight from the skid valid flop.
module if_id_buffer
  import if_id_pkg::*;
#(
  parameter int INST_SIZE = DEF_INST_SIZE,
  parameter int PC_SIZE   = DEF_PC_SIZE,
  parameter int CNT_SIZE  = DEF_CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_SIZE-1:0]   in_pc,
  input  logic [INST_SIZE-1:0] in_instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_SIZE-1:0]   out_pc,
  output logic [INST_SIZE-1:0] out_instruction,
  input  logic                 flush,
  output logic [CNT_SIZE-1:0]  flush_cnt
);

  state_e state_q, state_d;

  logic                 main_valid, skid_valid;
  logic [PC_SIZE-1:0]   main_pc, skid_pc;
  logic [INST_SIZE-1:0] main_instruction, skid_instruction;

  logic main_load, main_clr, main_from_skid;
  logic skid_load, skid_clr;
  logic acc, take;

  logic [PC_SIZE-1:0]   main_d_pc;
  logic [INST_SIZE-1:0] main_d_instruction;

  logic [CNT_SIZE-1:0] flush_cnt_q, flush_cnt_d;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign acc       = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      // A same-cycle take is still consumed by decode; an accepted beat is dropped.
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_load = 1'b1;
            state_d   = HALF;
          end
        end
        HALF: begin
          if (acc && take) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (take) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = HALF;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    main_d_pc          = in_pc;
    main_d_instruction = in_instruction;
    if (main_from_skid) begin
      main_d_pc          = skid_pc;
      main_d_instruction = skid_instruction;
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != {CNT_SIZE{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_entry #(
    .PC_SIZE   (PC_SIZE),
    .INST_SIZE (INST_SIZE)
  ) u_main (
    .clk           (clk),
    .rst           (rst),
    .load          (main_load),
    .clr           (main_clr),
    .d_pc          (main_d_pc),
    .d_instruction (main_d_instruction),
    .valid         (main_valid),
    .pc            (main_pc),
    .instruction   (main_instruction)
  );

  if_id_entry #(
    .PC_SIZE   (PC_SIZE),
    .INST_SIZE (INST_SIZE)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .load          (skid_load),
    .clr           (skid_clr),
    .d_pc          (in_pc),
    .d_instruction (in_instruction),
    .valid         (skid_valid),
    .pc            (skid_pc),
    .instruction   (skid_instruction)
  );

  assign out_pc          = main_pc;
  assign out_instruction = main_instruction;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomized and directed bench for if_id_buffer against a 2-deep FIFO queue model.
// Counter width is reduced so saturation is reachable in a handful of flushes.
module tb_if_id_buffer;

  localparam int INST_SIZE = 32;
  localparam int PC_SIZE   = 32;
  localparam int CNT_SIZE  = 2;
  localparam int CNT_MAX   = (1 << CNT_SIZE) - 1;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PC_SIZE-1:0]   in_pc;
  logic [INST_SIZE-1:0] in_instruction;
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_SIZE-1:0]   out_pc;
  logic [INST_SIZE-1:0] out_instruction;
  logic                 flush;
  logic [CNT_SIZE-1:0]  flush_cnt;

  if_id_buffer #(
    .INST_SIZE (INST_SIZE),
    .PC_SIZE   (PC_SIZE),
    .CNT_SIZE  (CNT_SIZE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .flush           (flush),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {pc, instruction}, capacity 2, head is what decode sees.
  logic [63:0] mq[$];
  int          cnt_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic legal;
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("flush_cnt", 64'(flush_cnt), 64'(cnt_m));
    legal = in_ready | out_valid;
    chk("legal_state", 64'(legal), 64'(1));
    if (mq.size() > 0) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0][63:32]));
      chk("out_instr", 64'(out_instruction), 64'(mq[0][31:0]));
    end
  endtask

  task automatic model_update(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                              input logic ordy, input logic fl);
    bit acc, take;
    acc  = iv && (mq.size() < 2);
    take = ordy && (mq.size() > 0);
    if (take) $display("[TB] t=%0t take pc=%08h instr=%08h", $time, mq[0][63:32], mq[0][31:0]);
    if (fl) begin
      if (cnt_m < CNT_MAX) cnt_m++;
      mq.delete();
      $display("[TB] t=%0t flush (acc=%0d dropped) cnt=%0d", $time, acc, cnt_m);
    end else begin
      if (take) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({pc, ins});
        $display("[TB] t=%0t accept pc=%08h instr=%08h", $time, pc, ins);
      end
    end
  endtask

  task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl);
    @(negedge clk);
    in_valid       = iv;
    in_pc          = pc;
    in_instruction = ins;
    out_ready      = ordy;
    flush          = fl;
    check_model();
    @(posedge clk);
    model_update(iv, pc, ins, ordy, fl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    in_valid       = 1'b0;
    in_pc          = '0;
    in_instruction = '0;
    out_ready      = 1'b0;
    flush          = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    chk("rst_out_instr", 64'(out_instruction), 64'(0));
    chk("rst_flush_cnt", 64'(flush_cnt), 64'(0));
    mq.delete();
    cnt_m = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    logic        riv, rordy, rfl;
    rst            = 1'b0;
    in_valid       = 1'b0;
    in_pc          = '0;
    in_instruction = '0;
    out_ready      = 1'b0;
    flush          = 1'b0;

    do_reset();

    // Counter saturation: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      #1;
      chk("sat_cnt", 64'(flush_cnt), 64'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1));
    end
    do_reset();

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0);
      #1;
      chk("stream_valid", 64'(out_valid), 64'(1));
      chk("stream_pc", 64'(out_pc), 64'(4 * i));
      chk("stream_ready", 64'(in_ready), 64'(1));
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("stream_drained", 64'(out_valid), 64'(0));

    // Backpressure into FULL, then drain in order
    cyc(1'b1, 32'h10, 32'hB0, 1'b0, 1'b0);
    cyc(1'b1, 32'h14, 32'hB1, 1'b0, 1'b0);
    #1;
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    chk("bp_hold_pc", 64'(out_pc), 64'h10);
    cyc(1'b1, 32'h18, 32'hB2, 1'b0, 1'b0);
    #1;
    chk("bp_hold_pc2", 64'(out_pc), 64'h10);
    cyc(1'b1, 32'h18, 32'hB2, 1'b1, 1'b0);
    #1;
    chk("bp_drain1", 64'(out_pc), 64'h14);
    cyc(1'b1, 32'h18, 32'hB2, 1'b1, 1'b0);
    #1;
    chk("bp_drain2", 64'(out_pc), 64'h18);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("bp_empty", 64'(out_valid), 64'(0));

    // Flush while FULL with an incoming beat
    cyc(1'b1, 32'h30, 32'hC0, 1'b0, 1'b0);
    cyc(1'b1, 32'h34, 32'hC1, 1'b0, 1'b0);
    cyc(1'b1, 32'h38, 32'hC2, 1'b0, 1'b1);
    #1;
    chk("flf_valid", 64'(out_valid), 64'(0));
    chk("flf_ready", 64'(in_ready), 64'(1));
    chk("flf_cnt", 64'(flush_cnt), 64'(1));
    cyc(1'b1, 32'h40, 32'hC4, 1'b0, 1'b0);
    #1;
    chk("flf_next_pc", 64'(out_pc), 64'h40);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("flf_alone", 64'(out_valid), 64'(0));

    // Flush in HALF with simultaneous accept and take
    cyc(1'b1, 32'h20, 32'hD0, 1'b0, 1'b0);
    cyc(1'b1, 32'h24, 32'hD1, 1'b1, 1'b1);
    #1;
    chk("flh_valid", 64'(out_valid), 64'(0));
    chk("flh_ready", 64'(in_ready), 64'(1));
    chk("flh_cnt", 64'(flush_cnt), 64'(2));

    // Asynchronous reset while FULL, observed before the next edge
    cyc(1'b1, 32'h50, 32'hE0, 1'b0, 1'b0);
    cyc(1'b1, 32'h54, 32'hE1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_pc", 64'(out_pc), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    chk("arst_cnt", 64'(flush_cnt), 64'(0));
    mq.delete();
    cnt_m = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 32'h60, 32'hE4, 1'b0, 1'b0);
    #1;
    chk("arst_first_pc", 64'(out_pc), 64'h60);
    chk("arst_first_valid", 64'(out_valid), 64'(1));

    // Randomized traffic
    rpc = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      riv   = ($urandom_range(0, 3) != 0);
      rordy = ($urandom_range(0, 9) < 7);
      rfl   = ($urandom_range(0, 15) == 0);
      cyc(riv, rpc, $urandom, rordy, rfl);
      if (riv) rpc = rpc + 32'd4;
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Elastic IF/ID pipeline register sitting between the instruction-fetch stage and the decode stage. It captures {PC, instruction} beats from fetch, holds them in a 2-entry skid buffer with valid/ready handshakes on both sides, and presents them to decode. Decode can stall it via out_ready and squash it via flush when a branch resolves taken.

Parameters:
INST_SIZE, 32, instruction width in bits
PC_SIZE, 32, program-counter width in bits
CNT_SIZE, 8, width of the saturating flush-event counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  fetch presents a beat
in_ready  output  1  buffer can accept a beat this cycle
in_pc  input  PC_SIZE  PC of the incoming beat
in_instruction  input  INST_SIZE  instruction of the incoming beat
out_valid  output  1  decode-side beat valid
out_ready  input  1  decode consumes the beat this cycle
out_pc  output  PC_SIZE  PC of the head beat
out_instruction  output  INST_SIZE  instruction of the head beat
flush  input  1  squash all buffered beats and the incoming beat (branch taken)
flush_cnt  output  CNT_SIZE  number of cycles with flush=1, saturating

Behaviour:
- Storage: main entry (drives out_*) and skid entry; each holds a valid bit, pc and instruction.
- Reset (rst=0, async): state EMPTY, both valid bits 0, all data 0, flush_cnt 0. Outputs: out_valid=0, in_ready=1, out_pc=0, out_instruction=0.
- in_ready = !skid_valid, taken directly from a register (no combinational path from out_ready). out_valid = main_valid.
- acc = in_valid & in_ready; take = out_valid & out_ready.
- States: EMPTY (main invalid), HALF (main valid, skid invalid), FULL (both valid).
- EMPTY: acc -> HALF, main<=in. !acc -> EMPTY.
- HALF: acc & take -> HALF, main<=in. acc & !take -> FULL, skid<=in. !acc & take -> EMPTY. Neither -> HALF, hold.
- FULL: in_ready=0, so acc is impossible. take -> HALF, main<=skid. !take -> FULL, hold.
- Latency: a beat accepted in cycle N is visible on out_* in cycle N+1. Sustained throughput is 1 beat/cycle when out_ready=1.
- Ordering: strict FIFO; the skid entry never overtakes the main entry.
- While out_valid=1 && out_ready=0, out_pc/out_instruction stay stable.
- flush=1 takes priority over everything. Next state EMPTY, both valid bits cleared, and any beat accepted this cycle (acc=1) is discarded. A take in the same cycle still counts as consumed by decode. Data registers keep their values (don't-care while invalid).
- flush_cnt increments by 1 on every cycle with flush=1 and saturates at 2^CNT_SIZE-1; it is only cleared by reset.
- Reset asserted mid-operation: all entries are lost immediately and asynchronously; the first beat after deassertion is accepted normally.
- Illegal state encoding (skid valid, main invalid) must be unreachable; assertion in the bench.

Decomposition:
- Package if_id_pkg: state enum (EMPTY=2'b00, HALF=2'b01, FULL=2'b11), and default widths INST_SIZE/PC_SIZE/CNT_SIZE as constants.
- Sub-module if_id_entry: one valid+pc+instruction register with async active-low reset, load enable and valid-clear. Instantiate twice (main, skid).
- Top level holds the state register, next-state/mux logic and flush_cnt.

Test Plan:
- Reset then stream: in_valid=1 with pc=0,4,8,12 (instr 0xA0..0xA3), out_ready=1 -> out_valid from cycle 1, out_pc 0,4,8,12 on consecutive cycles, in_ready always 1.
- Backpressure: out_ready=0, push pc=0x10,0x14 -> FULL, in_ready=0, out_pc holds 0x10; a third beat 0x18 held by fetch is not accepted. Release out_ready -> 0x10,0x14,0x18 in order, no loss or duplication.
- Flush in FULL with in_valid=1: flush=1 -> next cycle out_valid=0, in_ready=1, flush_cnt=1. The next accepted beat pc=0x40 appears alone.
- Flush in HALF with simultaneous acc and take: pc=0x20 in main, pc=0x24 incoming, out_ready=1, flush=1 -> 0x20 counted as consumed, 0x24 dropped, state EMPTY.
- Counter saturation with CNT_SIZE=2: 5 flush cycles -> flush_cnt 1,2,3,3,3.
- Async reset mid-FULL: drop rst between clock edges -> out_valid=0, out_pc=0, in_ready=1 immediately, before the next edge.
